gb_timer_intc: RTL and testbench

Memory-mapped timer and interrupt controller that sits directly upstream of `gb_cpu`. It owns the DIV, TIMA, TMA, TAC, IF and IE registers and drives the CPU's `reg_IF` and `reg_IE` inputs. It raises the timer interrupt internally and merges external interrupt requests. It consumes the CPU's `clear_interrupt_flag` pulse to acknowledge the highest-priority pending interrupt.

---
 rtl/gb_cpu_common_pkg.sv | 15 +
 rtl/gb_timer.sv | 81 ++++++++
 rtl/gb_timer_intc.sv | 76 +++++++
 tb/tb_gb_timer_intc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// gb_cpu_common_pkg: shared register addresses, timer FSM states and interrupt bit indices
package gb_cpu_common_pkg;
    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;
    localparam logic [15:0] ADDR_IF   = 16'hFF0F;
    localparam logic [15:0] ADDR_IE   = 16'hFFFF;
    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;
    typedef enum logic [1:0] {IDLE, OVF, RELOAD} timer_state_t;
endpackage

// File: rtl/gb_timer.sv
// gb_timer: divider, TAC-selected falling-edge tap, TIMA/TMA/TAC and overflow/reload FSM
//   in : clk, reset (async high), i_wr_div/i_wr_tima/i_wr_tma/i_wr_tac write strobes, i_data write data
//   out: timer_irq (combinational request, ORed into IF at the reload edge),
//        div_o (cnt[13:6]), tima_o, tma_o, tac_o
module gb_timer
    import gb_cpu_common_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_div,
    input  logic       i_wr_tima,
    input  logic       i_wr_tma,
    input  logic       i_wr_tac,
    input  logic [7:0] i_data,
    output logic       timer_irq,
    output logic [7:0] div_o,
    output logic [7:0] tima_o,
    output logic [7:0] tma_o,
    output logic [2:0] tac_o
);
    logic [13:0]  r_cnt;
    logic [7:0]   r_tima;
    logic [7:0]   r_tma;
    logic [2:0]   r_tac;
    logic         r_s_d;
    timer_state_t r_state;
    logic         w_tap;
    logic         w_s;
    logic         w_inc;

    assign w_tap     = r_tac[1] ? (r_tac[0] ? r_cnt[5] : r_cnt[3]) : (r_tac[0] ? r_cnt[1] : r_cnt[7]);
    assign w_s       = r_tac[2] & w_tap;
    // Falling edge of the gated tap; DIV resets and TAC changes can fake one
    assign w_inc     = r_s_d & ~w_s;
    // A TIMA write during OVF cancels the reload and its interrupt
    assign timer_irq = (r_state == OVF) && !i_wr_tima;
    assign div_o     = r_cnt[13:6];
    assign tima_o    = r_tima;
    assign tma_o     = r_tma;
    assign tac_o     = r_tac;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_s_d <= 1'b0;
            r_tma <= '0;
            r_tac <= '0;
        end else begin
            r_cnt <= i_wr_div ? 14'd0 : r_cnt + 14'd1;
            r_s_d <= w_s;
            r_tma <= i_wr_tma ? i_data : r_tma;
            r_tac <= i_wr_tac ? i_data[2:0] : r_tac;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tima  <= '0;
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_wr_tima) begin
                        r_tima <= i_data;
                    end else if (w_inc) begin
                        r_tima  <= r_tima + 8'd1;
                        r_state <= (r_tima == 8'hFF) ? OVF : IDLE;
                    end
                end
                OVF: begin
                    r_tima  <= i_wr_tima ? i_data : (i_wr_tma ? i_data : r_tma);
                    r_state <= i_wr_tima ? IDLE : RELOAD;
                end
                default: begin
                    r_tima  <= i_wr_tma ? i_data : r_tima;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: rtl/gb_timer_intc.sv
// gb_timer_intc: memory-mapped timer plus IF/IE interrupt controller feeding gb_cpu
//   in : clk, reset (async high), addr_i/data_i/wr_en CPU bus, irq_req_i external requests,
//        clear_interrupt_flag CPU acknowledge
//   out: data_o/data_o_valid combinational read port, reg_IF {3'b0, IF}, reg_IE
module gb_timer_intc
    import gb_cpu_common_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        wr_en,
    input  logic [4:0]  irq_req_i,
    input  logic        clear_interrupt_flag,
    output logic [7:0]  data_o,
    output logic        data_o_valid,
    output logic [7:0]  reg_IF,
    output logic [7:0]  reg_IE
);
    logic [4:0] r_if;
    logic [7:0] r_ie;
    logic       w_timer_irq;
    logic [7:0] w_div;
    logic [7:0] w_tima;
    logic [7:0] w_tma;
    logic [2:0] w_tac;
    logic [4:0] w_if_wr;
    logic [4:0] w_if_clr;
    logic [4:0] w_if_next;

    gb_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_wr_div  (wr_en && addr_i == ADDR_DIV),
        .i_wr_tima (wr_en && addr_i == ADDR_TIMA),
        .i_wr_tma  (wr_en && addr_i == ADDR_TMA),
        .i_wr_tac  (wr_en && addr_i == ADDR_TAC),
        .i_data    (data_i),
        .timer_irq (w_timer_irq),
        .div_o     (w_div),
        .tima_o    (w_tima),
        .tma_o     (w_tma),
        .tac_o     (w_tac)
    );

    // Write, then acknowledge lowest set bit, then merge new requests so they win
    assign w_if_wr   = (wr_en && addr_i == ADDR_IF) ? data_i[4:0] : r_if;
    assign w_if_clr  = clear_interrupt_flag ? (w_if_wr & (w_if_wr - 5'd1)) : w_if_wr;
    assign w_if_next = w_if_clr | irq_req_i | (5'(w_timer_irq) << INT_TIMER);
    assign reg_IF    = {3'b000, r_if};
    assign reg_IE    = r_ie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if <= '0;
            r_ie <= '0;
        end else begin
            r_if <= w_if_next;
            r_ie <= (wr_en && addr_i == ADDR_IE) ? data_i : r_ie;
        end
    end

    always_comb begin
        data_o       = 8'h00;
        data_o_valid = 1'b1;
        case (addr_i)
            ADDR_DIV:  data_o = w_div;
            ADDR_TIMA: data_o = w_tima;
            ADDR_TMA:  data_o = w_tma;
            ADDR_TAC:  data_o = {5'b11111, w_tac};
            ADDR_IF:   data_o = {3'b111, r_if};
            ADDR_IE:   data_o = r_ie;
            default:   data_o_valid = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_gb_timer_intc.sv
// tb_gb_timer_intc: directed self-checking bench for gb_timer_intc
module tb_gb_timer_intc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr_i = 16'h0000;
    logic [7:0]  data_i = 8'h00;
    logic        wr_en = 1'b0;
    logic [4:0]  irq_req_i = 5'h00;
    logic        clear_interrupt_flag = 1'b0;
    logic [7:0]  data_o;
    logic        data_o_valid;
    logic [7:0]  reg_IF;
    logic [7:0]  reg_IE;
    int errors = 0;
    int checks = 0;

    gb_timer_intc dut (
        .clk                  (clk),
        .reset                (reset),
        .addr_i               (addr_i),
        .data_i               (data_i),
        .wr_en                (wr_en),
        .irq_req_i            (irq_req_i),
        .clear_interrupt_flag (clear_interrupt_flag),
        .data_o               (data_o),
        .data_o_valid         (data_o_valid),
        .reg_IF               (reg_IF),
        .reg_IE               (reg_IE)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr_i = a;
        data_i = d;
        wr_en  = 1'b1;
        @(negedge clk);
        wr_en  = 1'b0;
        addr_i = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        addr_i = a;
        #1 d = data_o;
    endtask

    task automatic pulse_irq(input logic [4:0] req, input logic clr);
        irq_req_i = req;
        clear_interrupt_flag = clr;
        @(negedge clk);
        irq_req_i = 5'h00;
        clear_interrupt_flag = 1'b0;
    endtask

    // Polls TIMA each cycle until it goes FF->00; returns in the OVF cycle
    task automatic wait_ovf(output bit ok, output int period);
        logic [7:0] prev;
        logic [7:0] cur;
        int t = 0;
        int t_ff = -100;
        ok = 1'b0;
        period = -1;
        rd(16'hFF05, prev);
        while (!ok && t < 300) begin
            @(negedge clk);
            rd(16'hFF05, cur);
            t++;
            if (prev == 8'hFE && cur == 8'hFF) t_ff = t;
            if (prev == 8'hFF && cur == 8'h00) begin
                ok = 1'b1;
                period = t - t_ff;
            end
            prev = cur;
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (reg_IF !== 8'h00) begin errors++; $display("FAIL reset_reg_IF got=%h exp=00", reg_IF); end
        checks++; if (reg_IE !== 8'h00) begin errors++; $display("FAIL reset_reg_IE got=%h exp=00", reg_IE); end
        rd(16'hFF07, d);
        checks++; if (d !== 8'hF8 || data_o_valid !== 1'b1) begin errors++; $display("FAIL reset_tac got=%h v=%b exp=f8 v=1", d, data_o_valid); end
        rd(16'hFF0F, d);
        checks++; if (d !== 8'hE0) begin errors++; $display("FAIL reset_if got=%h exp=e0", d); end
        rd(16'hFFFF, d);
        checks++; if (d !== 8'h00 || data_o_valid !== 1'b1) begin errors++; $display("FAIL reset_ie got=%h v=%b exp=00 v=1", d, data_o_valid); end
        @(negedge clk);
        rd(16'hFF05, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_tima got=%h exp=00", d); end
        rd(16'hFF04, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_div got=%h exp=00", d); end
        rd(16'h1234, d);
        checks++; if (d !== 8'h00 || data_o_valid !== 1'b0) begin errors++; $display("FAIL miss_read got=%h v=%b exp=00 v=0", d, data_o_valid); end
    endtask

    task automatic test_timer_overflow;
        logic [7:0] d;
        bit ok;
        int period;
        wr(16'hFF07, 8'h05);
        wr(16'hFF06, 8'hF0);
        wr(16'hFF05, 8'hFE);
        wait_ovf(ok, period);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got=%0d exp=1", ok); end
        checks++; if (period !== 4) begin errors++; $display("FAIL inc_period got=%0d exp=4", period); end
        checks++; if (reg_IF !== 8'h00) begin errors++; $display("FAIL ovf_cycle_if got=%h exp=00", reg_IF); end
        @(negedge clk);
        rd(16'hFF05, d);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL reload_tima got=%h exp=f0", d); end
        checks++; if (reg_IF !== 8'h04) begin errors++; $display("FAIL reload_if got=%h exp=04", reg_IF); end
    endtask

    task automatic test_ovf_write;
        logic [7:0] d;
        bit ok;
        int period;
        wr(16'hFF0F, 8'h00);
        wr(16'hFF05, 8'hFE);
        wait_ovf(ok, period);
        checks++; if (!ok) begin errors++; $display("FAIL ovf2_timeout got=%0d exp=1", ok); end
        wr(16'hFF05, 8'h33);
        rd(16'hFF05, d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL ovf_write_tima got=%h exp=33", d); end
        checks++; if (reg_IF !== 8'h00) begin errors++; $display("FAIL ovf_write_if got=%h exp=00", reg_IF); end
        repeat (3) @(negedge clk);
        checks++; if (reg_IF !== 8'h00) begin errors++; $display("FAIL ovf_write_if_later got=%h exp=00", reg_IF); end
        wr(16'hFF05, 8'hFE);
        wait_ovf(ok, period);
        checks++; if (!ok) begin errors++; $display("FAIL ovf3_timeout got=%0d exp=1", ok); end
        @(negedge clk);
        wr(16'hFF05, 8'h77);
        rd(16'hFF05, d);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL reload_write_tima got=%h exp=f0", d); end
        checks++; if (reg_IF !== 8'h04) begin errors++; $display("FAIL reload_write_if got=%h exp=04", reg_IF); end
    endtask

    task automatic test_div_write;
        logic [7:0] d;
        logic [7:0] base;
        bit found = 1'b0;
        wr(16'hFF07, 8'h04);
        wr(16'hFF05, 8'h10);
        repeat (200) @(negedge clk);
        for (int i = 0; i < 300 && !found; i++) begin
            rd(16'hFF04, d);
            if (d[1]) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL div_bit7_timeout got=%0d exp=1", found); end
        rd(16'hFF05, base);
        wr(16'hFF04, 8'hAB);
        rd(16'hFF04, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL div_cleared got=%h exp=00", d); end
        rd(16'hFF05, d);
        checks++; if (d !== base) begin errors++; $display("FAIL div_tima_pending got=%h exp=%h", d, base); end
        @(negedge clk);
        rd(16'hFF05, d);
        checks++; if (d !== base + 8'd1) begin errors++; $display("FAIL div_spurious_inc got=%h exp=%h", d, base + 8'd1); end
    endtask

    task automatic test_irq;
        logic [7:0] d;
        wr(16'hFF07, 8'h00);
        wr(16'hFF0F, 8'h00);
        wr(16'hFFFF, 8'h1F);
        checks++; if (reg_IE !== 8'h1F) begin errors++; $display("FAIL ie_write got=%h exp=1f", reg_IE); end
        pulse_irq(5'h05, 1'b0);
        checks++; if (reg_IF !== 8'h05) begin errors++; $display("FAIL irq_req got=%h exp=05", reg_IF); end
        rd(16'hFF0F, d);
        checks++; if (d !== 8'hE5) begin errors++; $display("FAIL if_read got=%h exp=e5", d); end
        pulse_irq(5'h00, 1'b1);
        checks++; if (reg_IF !== 8'h04) begin errors++; $display("FAIL clear1 got=%h exp=04", reg_IF); end
        pulse_irq(5'h00, 1'b1);
        checks++; if (reg_IF !== 8'h00) begin errors++; $display("FAIL clear2 got=%h exp=00", reg_IF); end
        pulse_irq(5'h00, 1'b1);
        checks++; if (reg_IF !== 8'h00) begin errors++; $display("FAIL clear_empty got=%h exp=00", reg_IF); end
        pulse_irq(5'h01, 1'b0);
        pulse_irq(5'h01, 1'b1);
        checks++; if (reg_IF !== 8'h01) begin errors++; $display("FAIL clear_vs_req got=%h exp=01", reg_IF); end
        clear_interrupt_flag = 1'b1;
        wr(16'hFF0F, 8'h06);
        clear_interrupt_flag = 1'b0;
        checks++; if (reg_IF !== 8'h04) begin errors++; $display("FAIL write_then_clear got=%h exp=04", reg_IF); end
        wr(16'hFFFF, 8'hFF);
        checks++; if (reg_IE !== 8'hFF) begin errors++; $display("FAIL ie_full got=%h exp=ff", reg_IE); end
    endtask

    task automatic test_reset_in_ovf;
        logic [7:0] d;
        bit ok;
        int period;
        wr(16'hFF0F, 8'h00);
        wr(16'hFF07, 8'h05);
        wr(16'hFF06, 8'hF0);
        wr(16'hFF05, 8'hFE);
        wait_ovf(ok, period);
        checks++; if (!ok) begin errors++; $display("FAIL ovf4_timeout got=%0d exp=1", ok); end
        reset = 1'b1;
        rd(16'hFF05, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_tima got=%h exp=00", d); end
        checks++; if (reg_IE !== 8'h00) begin errors++; $display("FAIL rst_ie got=%h exp=00", reg_IE); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (reg_IF !== 8'h00) begin errors++; $display("FAIL rst_no_irq cycle=%0d got=%h exp=00", i, reg_IF); end
        end
        rd(16'hFF05, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_tima_after got=%h exp=00", d); end
    endtask

    initial begin
        test_reset;
        test_timer_overflow;
        test_ovf_write;
        test_div_write;
        test_irq;
        test_reset_in_ovf;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
